// File: rtl/window_gen_5x5_45.sv
// window_gen_5x5_45: streaming 5x5 sliding-window generator; ports: clk, rst_n (sync active-low), in_valid/in_sof/pixel_in in, out_valid/window_o/out_row/out_col/frame_done out
module window_gen_5x5_45 #(
  parameter int PIX_W      = 9,
  parameter int IMG_WIDTH  = 516,
  parameter int IMG_HEIGHT = 516,
  parameter int KSIZE      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [PIX_W-1:0]     pixel_in,
  output logic                 out_valid,
  output logic [25*PIX_W-1:0]  window_o,
  output logic [15:0]          out_row,
  output logic [15:0]          out_col,
  output logic                 frame_done
);
  localparam int AW = $clog2(IMG_WIDTH);
  if (KSIZE != 5) begin : g_ksize
    $error("KSIZE must be 5");
  end
  logic [15:0] col, row, pc, pr;
  logic [AW-1:0] a;
  logic last_col, last_row;
  logic [PIX_W-1:0] lb [4][IMG_WIDTH];
  logic [PIX_W-1:0] win [5][5];
  logic [PIX_W-1:0] newcol [5];
  assign pc = in_sof ? '0 : col;
  assign pr = in_sof ? '0 : row;
  assign a = pc[AW-1:0];
  assign last_col = pc == 16'(IMG_WIDTH - 1);
  assign last_row = pr == 16'(IMG_HEIGHT - 1);
  always_comb begin
    newcol[4] = pixel_in;
    for (int k = 0; k < 4; k++) newcol[3-k] = lb[k][a];
  end
  always_ff @(posedge clk) begin
    if (rst_n && in_valid) begin
      lb[0][a] <= pixel_in;
      for (int k = 0; k < 3; k++) lb[k+1][a] <= lb[k][a];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) win[i][j] <= '0;
    end else begin
      out_valid  <= in_valid && pr >= 16'd4 && pc >= 16'd4;
      frame_done <= in_valid && last_col && last_row;
      if (in_valid) begin
        col     <= last_col ? '0 : pc + 16'd1;
        row     <= last_col ? (last_row ? '0 : pr + 16'd1) : pr;
        out_row <= pr;
        out_col <= pc;
        for (int i = 0; i < 5; i++) begin
          for (int j = 0; j < 4; j++) win[i][j] <= win[i][j+1];
          win[i][4] <= newcol[i];
        end
      end
    end
  end
  for (genvar i = 0; i < 5; i++) begin : g_r
    for (genvar j = 0; j < 5; j++) begin : g_c
      assign window_o[(i*5+j)*PIX_W +: PIX_W] = win[i][j];
    end
  end
endmodule

// File: tb/tb_window_gen_5x5_45.sv
// tb_window_gen_5x5_45: randomized self-checking bench against a frame-image reference model
module tb_window_gen_5x5_45;
  localparam int W = 8, H = 6, P = 9;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [P-1:0] pixel_in = '0;
  logic out_valid, frame_done;
  logic [25*P-1:0] window_o;
  logic [15:0] out_row, out_col;
  int checks = 0, errors = 0;
  int n = 0, nwin = 0, nfd = 0, acc = 0, first_acc = 0;
  logic [P-1:0] img [H][W];
  logic [15:0] er = '0, ec = '0;
  logic [25*P-1:0] first_w = '0, last_w = '0, ones_w;
  window_gen_5x5_45 #(.PIX_W(P), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KSIZE(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .pixel_in(pixel_in),
    .out_valid(out_valid), .window_o(window_o), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic v, input logic s, input logic [P-1:0] p);
    logic ev, efd;
    logic [25*P-1:0] ew;
    int r, c;
    ev = 1'b0; efd = 1'b0; ew = '0;
    in_valid = v; in_sof = s; pixel_in = p;
    if (v) begin
      if (s) n = 0;
      r = n / W; c = n % W;
      img[r][c] = p;
      ev = r >= 4 && c >= 4;
      efd = n == W*H - 1;
      er = 16'(r); ec = 16'(c);
      n = (n + 1) % (W*H);
      if (ev) for (int k = 0; k < 25; k++) ew[k*P +: P] = img[r-4+k/5][c-4+k%5];
      acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
    check("out_valid", out_valid, ev);
    check("frame_done", frame_done, efd);
    check("out_row", out_row, er);
    check("out_col", out_col, ec);
    if (ev) check("window", window_o, ew);
    if (out_valid) begin
      if (nwin == 0) begin first_w = window_o; first_acc = acc; end
      last_w = window_o;
      nwin++;
    end
    if (frame_done) nfd++;
  endtask
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) begin
      in_valid = 1'b1; pixel_in = P'($urandom);
      @(posedge clk); #1;
      check("rst_valid", out_valid, 0);
      check("rst_fdone", frame_done, 0);
      check("rst_window", window_o, 0);
      check("rst_row", out_row, 0);
      check("rst_col", out_col, 0);
    end
    in_valid = 1'b0; rst_n = 1'b1;
    n = 0; er = '0; ec = '0;
  endtask
  task automatic start();
    nwin = 0; nfd = 0; acc = 0; first_acc = 0;
  endtask
  task automatic frame(input int kind, input bit gap, input bit sof, input int cnt);
    logic [P-1:0] p;
    for (int i = 0; i < cnt; i++) begin
      if (gap) repeat ($urandom_range(0, 2)) send(1'b0, 1'b0, P'($urandom));
      p = kind == 0 ? P'(16*(i/W) + i%W) : kind == 1 ? P'($urandom) : (i == 4*W+4 ? 9'h100 : 9'd1);
      send(1'b1, sof && i == 0, p);
    end
  endtask
  initial begin
    do_reset(2);
    start(); frame(0, 0, 0, W*H); send(0, 0, 0);
    check("t1_count", nwin, 8);
    check("t1_first_acc", first_acc, 37);
    check("t1_p1", first_w[0 +: P], 0);
    check("t1_p13", first_w[12*P +: P], 34);
    check("t1_p25", first_w[24*P +: P], 68);
    check("t1_last_p25", last_w[24*P +: P], 87);
    start(); frame(0, 1, 0, W*H);
    check("t2_count", nwin, 8);
    check("t2_p25", first_w[24*P +: P], 68);
    check("t2_last_p25", last_w[24*P +: P], 87);
    start(); frame(1, 1, 1, W*H); frame(1, 0, 1, W*H);
    check("t3_fdone", nfd, 2);
    check("t3_count", nwin, 16);
    frame(1, 0, 0, 3*W+2);
    start(); frame(1, 1, 1, W*H);
    check("t4_first_acc", first_acc, 37);
    check("t4_fdone", nfd, 1);
    check("t4_count", nwin, 8);
    frame(0, 0, 0, 4*W+6);
    do_reset(2);
    start(); frame(0, 0, 0, W*H);
    check("t5_count", nwin, 8);
    check("t5_p25", first_w[24*P +: P], 68);
    check("t5_last_p25", last_w[24*P +: P], 87);
    start(); frame(2, 1, 1, W*H);
    ones_w = '0;
    for (int k = 0; k < 24; k++) ones_w[k*P +: P] = 9'd1;
    check("t6_p25", first_w[24*P +: P], 9'h100);
    check("t6_p1_24", {9'd0, first_w[24*P-1:0]}, ones_w);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
